// File: rtl/fec_erasure_pkg.sv
// Shared types and constants for the FEC erasure channel.
// LFSR constants are only consumed when FEC_ERASURE_LFSR_EN is defined.
package fec_erasure_pkg;

    localparam int DAT_W = 16;
    localparam int ADR_W = 2;
    localparam int SEL_W = 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_DROP,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } fab_word_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/fec_erasure_skid.sv
// Two-entry fabric skid buffer: output register plus skid register,
// with a registered stall so the upstream path stays short.
module fec_erasure_skid
    import fec_erasure_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  fab_word_t din,
    input  logic      out_stall,
    output logic      out_vld,
    output fab_word_t dout,
    output logic      stall,
    output logic      empty
);

    fab_word_t skid_q;
    logic      skid_vld;
    logic      pop;

    assign pop   = out_vld & ~out_stall;
    assign empty = ~out_vld & ~skid_vld;

    // One word may still arrive the cycle a stall is first seen;
    // it parks in the skid entry and drains first on release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            dout     <= '0;
            skid_q   <= '0;
            stall    <= 1'b0;
        end else begin
            stall <= out_vld & out_stall;
            if (!out_vld || pop) begin
                if (skid_vld) begin
                    dout     <= skid_q;
                    out_vld  <= 1'b1;
                    skid_vld <= push;
                    if (push) skid_q <= din;
                end else begin
                    out_vld <= push;
                    if (push) dout <= din;
                end
            end else if (push) begin
                skid_vld <= 1'b1;
                skid_q   <= din;
            end
        end
    end

endmodule

// File: rtl/fec_erasure_channel.sv
// Lossy-link emulator: forwards or erases whole fabric frames.
// Define FEC_ERASURE_LFSR_EN to add pseudo-random drops.
module fec_erasure_channel
    import fec_erasure_pkg::*;
#(
    parameter int g_period_w = 8,
    parameter int g_cnt_w    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  snk_cyc_i,
    input  logic                  snk_stb_i,
    input  logic                  snk_we_i,
    input  logic [SEL_W-1:0]      snk_sel_i,
    input  logic [ADR_W-1:0]      snk_adr_i,
    input  logic [DAT_W-1:0]      snk_dat_i,
    output logic                  snk_ack_o,
    output logic                  snk_stall_o,
    output logic                  src_cyc_o,
    output logic                  src_stb_o,
    output logic                  src_we_o,
    output logic [SEL_W-1:0]      src_sel_o,
    output logic [ADR_W-1:0]      src_adr_o,
    output logic [DAT_W-1:0]      src_dat_o,
    input  logic                  src_ack_i,
    input  logic                  src_stall_i,
    input  logic                  cfg_en_i,
    input  logic [g_period_w-1:0] cfg_period_i,
    input  logic [15:0]           cfg_thresh_i,
    output logic [g_cnt_w-1:0]    frames_o,
    output logic [g_cnt_w-1:0]    dropped_o
);

    state_t                state, state_n;
    logic                  armed;
    logic                  ack_q, hold_q;
    logic [g_period_w-1:0] per_cnt;
    logic [g_cnt_w-1:0]    frames_q, dropped_q;
    logic                  start, per_hit, rnd_hit, drop;
    logic                  stb_in, acc_fwd, acc_drop;
    logic                  skid_stall, skid_empty;
    fab_word_t             in_w, out_w;
    logic                  unused_in;

    assign in_w = {snk_we_i, snk_sel_i, snk_adr_i, snk_dat_i};
    assign {src_we_o, src_sel_o, src_adr_o, src_dat_o} = out_w;

    assign snk_ack_o   = ack_q;
    assign snk_stall_o = skid_stall | hold_q;
    assign frames_o    = frames_q;
    assign dropped_o   = dropped_q;

    // armed blocks a frame that was already open when reset released
    assign start   = (state == S_IDLE) & snk_cyc_i & armed;
    assign per_hit = (cfg_period_i != '0) &&
                     (per_cnt == cfg_period_i - g_period_w'(1));
    assign drop    = cfg_en_i & (per_hit | rnd_hit);
    assign stb_in  = snk_cyc_i & snk_stb_i & ~snk_stall_o;

`ifdef FEC_ERASURE_LFSR_EN
    logic [15:0] lfsr_q;

    assign rnd_hit   = lfsr_q < cfg_thresh_i;
    assign unused_in = src_ack_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)   lfsr_q <= LFSR_SEED;
        else if (start) lfsr_q <= lfsr_next(lfsr_q);
    end
`else
    assign rnd_hit   = 1'b0;
    assign unused_in = ^{src_ack_i, cfg_thresh_i};
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start) state_n = drop ? S_DROP : S_FWD;
            S_FWD:   if (!snk_cyc_i) state_n = S_FLUSH;
            S_DROP:  if (!snk_cyc_i) state_n = S_IDLE;
            S_FLUSH: if (skid_empty) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        acc_fwd   = 1'b0;
        acc_drop  = 1'b0;
        src_cyc_o = 1'b0;
        unique case (state)
            S_IDLE: begin
                acc_fwd  = start & ~drop & stb_in;
                acc_drop = start & drop & stb_in;
            end
            S_FWD: begin
                src_cyc_o = 1'b1;
                acc_fwd   = stb_in;
            end
            S_DROP:  acc_drop = stb_in;
            S_FLUSH: src_cyc_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            armed     <= 1'b0;
            ack_q     <= 1'b0;
            hold_q    <= 1'b0;
            per_cnt   <= '0;
            frames_q  <= '0;
            dropped_q <= '0;
        end else begin
            armed  <= start ? 1'b0 : (armed | ~snk_cyc_i);
            ack_q  <= acc_fwd | acc_drop;
            hold_q <= (state_n == S_FLUSH);
            if (start) begin
                frames_q <= frames_q + g_cnt_w'(1);
                per_cnt  <= (per_hit || cfg_period_i == '0) ?
                            '0 : per_cnt + g_period_w'(1);
            end
            if (state == S_DROP && !snk_cyc_i)
                dropped_q <= dropped_q + g_cnt_w'(1);
        end
    end

    fec_erasure_skid u_skid (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (acc_fwd),
        .din       (in_w),
        .out_stall (src_stall_i),
        .out_vld   (src_stb_o),
        .dout      (out_w),
        .stall     (skid_stall),
        .empty     (skid_empty)
    );

endmodule

// File: tb/tb_fec_erasure_channel.sv
// Directed bench for fec_erasure_channel.
// LFSR scenarios run only when FEC_ERASURE_LFSR_EN is defined.
module tb_fec_erasure_channel;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        snk_cyc_i = 1'b0, snk_stb_i = 1'b0, snk_we_i = 1'b0;
    logic [1:0]  snk_sel_i = '0, snk_adr_i = '0;
    logic [15:0] snk_dat_i = '0;
    logic        snk_ack_o, snk_stall_o;
    logic        src_cyc_o, src_stb_o, src_we_o;
    logic [1:0]  src_sel_o, src_adr_o;
    logic [15:0] src_dat_o;
    logic        src_ack_i = 1'b0, src_stall_i = 1'b0;
    logic        cfg_en_i = 1'b0;
    logic [7:0]  cfg_period_i = '0;
    logic [15:0] cfg_thresh_i = '0;
    logic [31:0] frames_o, dropped_o;

    int checks = 0;
    int failures = 0;

    logic [20:0] rx_q[$];
    logic [20:0] exp_q[$];
    int          rx_len_q[$];
    int          cur_len = 0;
    int          ack_total = 0;
    int          stall_cnt = 0;
    logic        cyc_prev = 1'b0;
    bit          rnd_stall = 1'b0;

    always #5 clk = ~clk;

    fec_erasure_channel dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .snk_cyc_i    (snk_cyc_i),
        .snk_stb_i    (snk_stb_i),
        .snk_we_i     (snk_we_i),
        .snk_sel_i    (snk_sel_i),
        .snk_adr_i    (snk_adr_i),
        .snk_dat_i    (snk_dat_i),
        .snk_ack_o    (snk_ack_o),
        .snk_stall_o  (snk_stall_o),
        .src_cyc_o    (src_cyc_o),
        .src_stb_o    (src_stb_o),
        .src_we_o     (src_we_o),
        .src_sel_o    (src_sel_o),
        .src_adr_o    (src_adr_o),
        .src_dat_o    (src_dat_o),
        .src_ack_i    (src_ack_i),
        .src_stall_i  (src_stall_i),
        .cfg_en_i     (cfg_en_i),
        .cfg_period_i (cfg_period_i),
        .cfg_thresh_i (cfg_thresh_i),
        .frames_o     (frames_o),
        .dropped_o    (dropped_o)
    );

    // downstream stall generator
    always @(posedge clk) begin
        #1;
        src_stall_i = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge clk) begin
        if (snk_ack_o) ack_total++;
        if (snk_stall_o && src_stb_o) stall_cnt++;
        if (cyc_prev && !src_cyc_o) begin
            rx_len_q.push_back(cur_len);
            cur_len = 0;
        end
        if (src_cyc_o && src_stb_o && !src_stall_i) begin
            rx_q.push_back({src_we_o, src_sel_o, src_adr_o, src_dat_o});
            cur_len++;
        end
        cyc_prev = src_cyc_o;
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [20:0] mk(input int f, input int i);
        logic [15:0] d;
        logic [1:0]  s, a;
        logic        w;
        d = 16'(f * 4096 + i);
        s = 2'(i + f);
        a = 2'(i >> 2);
        w = 1'(i ^ f);
        return {w, s, a, d};
    endfunction

    function automatic int cmp_rx(input int rb);
        int bad = 0;
        if (rx_q.size() - rb != exp_q.size()) return 1 + exp_q.size();
        for (int k = 0; k < exp_q.size(); k++)
            if (rx_q[rb + k] !== exp_q[k]) bad++;
        return bad;
    endfunction

    function automatic int bad_lens(input int lb, input int len);
        int bad = 0;
        for (int k = lb; k < rx_len_q.size(); k++)
            if (rx_len_q[k] != len) bad++;
        return bad;
    endfunction

    task automatic do_reset();
        rst_n_i   = 1'b0;
        snk_cyc_i = 1'b0;
        snk_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int f, input int nw, input int gap);
        int  i = 0;
        int  guard = 0;
        int  a0 = ack_total;
        bit  st;
        snk_cyc_i = 1'b1;
        while (i < nw && guard < 20000) begin
            snk_stb_i = 1'b1;
            {snk_we_i, snk_sel_i, snk_adr_i, snk_dat_i} = mk(f, i);
            @(negedge clk);
            st = snk_stall_o;
            @(posedge clk);
            #1;
            if (!st) i++;
            guard++;
        end
        snk_stb_i = 1'b0;
        guard = 0;
        while (ack_total - a0 < nw && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        snk_cyc_i = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (src_cyc_o !== 1'b0) begin
            failures++; $display("FAIL rst_src_cyc got=%0b exp=0", src_cyc_o);
        end
        checks++;
        if (src_stb_o !== 1'b0) begin
            failures++; $display("FAIL rst_src_stb got=%0b exp=0", src_stb_o);
        end
        checks++;
        if ({snk_ack_o, snk_stall_o} !== 2'b00) begin
            failures++;
            $display("FAIL rst_snk got=%0b%0b exp=00", snk_ack_o, snk_stall_o);
        end
        checks++;
        if ({src_we_o, src_sel_o, src_adr_o, src_dat_o} !== 21'h0) begin
            failures++;
            $display("FAIL rst_src_word got=%0h exp=0", src_dat_o);
        end
        checks++;
        if (frames_o !== 32'd0 || dropped_o !== 32'd0) begin
            failures++;
            $display("FAIL rst_cnt got=%0d/%0d exp=0/0", frames_o, dropped_o);
        end
        @(posedge clk);
        #1 rst_n_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        do_reset();
        cfg_en_i = 1'b0; cfg_period_i = 8'd0;
        snk_cyc_i = 1'b1;
        snk_stb_i = 1'b1;
        {snk_we_i, snk_sel_i, snk_adr_i, snk_dat_i} = mk(1, 5);
        @(posedge clk);
        #1 snk_stb_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({src_cyc_o, src_stb_o} !== 2'b11) begin
            failures++;
            $display("FAIL lat_stb got=%0b%0b exp=11", src_cyc_o, src_stb_o);
        end
        checks++;
        if ({src_we_o, src_sel_o, src_adr_o, src_dat_o} !== mk(1, 5)) begin
            failures++;
            $display("FAIL lat_word got=%0h exp=%0h", src_dat_o, mk(1, 5));
        end
        checks++;
        if (snk_ack_o !== 1'b1) begin
            failures++; $display("FAIL lat_ack got=%0b exp=1", snk_ack_o);
        end
        @(posedge clk);
        #1 snk_cyc_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (frames_o !== 32'd1 || src_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL lat_end got=%0d/%0b exp=1/0", frames_o, src_cyc_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_periodic();
        int rb, lb, a0, nb;
        do_reset();
        cfg_en_i = 1'b1; cfg_period_i = 8'd4; cfg_thresh_i = 16'd0;
        rb = rx_q.size(); lb = rx_len_q.size(); a0 = ack_total;
        exp_q.delete();
        for (int f = 1; f <= 8; f++) begin
            send_frame(f, 250, 3);
            if (f % 4 != 0)
                for (int i = 0; i < 250; i++) exp_q.push_back(mk(f, i));
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (frames_o !== 32'd8 || dropped_o !== 32'd2) begin
            failures++;
            $display("FAIL per_cnt got=%0d/%0d exp=8/2", frames_o, dropped_o);
        end
        checks++;
        if (rx_len_q.size() - lb != 6 || bad_lens(lb, 250) != 0) begin
            failures++;
            $display("FAIL per_frames got=%0d exp=6", rx_len_q.size() - lb);
        end
        nb = cmp_rx(rb);
        checks++;
        if (nb != 0) begin
            failures++; $display("FAIL per_data got=%0d bad exp=0", nb);
        end
        checks++;
        if (ack_total - a0 != 2000) begin
            failures++;
            $display("FAIL per_acks got=%0d exp=2000", ack_total - a0);
        end
    endtask

    task automatic test_passthrough();
        int rb, lb, a0, nb;
        do_reset();
        cfg_en_i = 1'b0; cfg_period_i = 8'd1;
        rb = rx_q.size(); lb = rx_len_q.size(); a0 = ack_total;
        exp_q.delete();
        for (int f = 1; f <= 10; f++) begin
            send_frame(f, 20, 2);
            for (int i = 0; i < 20; i++) exp_q.push_back(mk(f, i));
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (frames_o !== 32'd10 || dropped_o !== 32'd0) begin
            failures++;
            $display("FAIL pass_cnt got=%0d/%0d exp=10/0", frames_o, dropped_o);
        end
        checks++;
        if (rx_len_q.size() - lb != 10 || bad_lens(lb, 20) != 0) begin
            failures++;
            $display("FAIL pass_frames got=%0d exp=10", rx_len_q.size() - lb);
        end
        nb = cmp_rx(rb);
        checks++;
        if (nb != 0 || ack_total - a0 != 200) begin
            failures++;
            $display("FAIL pass_data got=%0d bad/%0d acks exp=0/200",
                     nb, ack_total - a0);
        end
    endtask

    task automatic test_stalls();
        int rb, lb, a0, s0, nb;
        do_reset();
        cfg_en_i = 1'b1; cfg_period_i = 8'd0;
        rb = rx_q.size(); lb = rx_len_q.size();
        a0 = ack_total; s0 = stall_cnt;
        exp_q.delete();
        rnd_stall = 1'b1;
        for (int f = 1; f <= 2; f++) begin
            send_frame(f, 750, 2);
            for (int i = 0; i < 750; i++) exp_q.push_back(mk(f, i));
        end
        rnd_stall = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (frames_o !== 32'd2 || dropped_o !== 32'd0) begin
            failures++;
            $display("FAIL stall_cnt got=%0d/%0d exp=2/0", frames_o, dropped_o);
        end
        checks++;
        if (rx_len_q.size() - lb != 2 || bad_lens(lb, 750) != 0) begin
            failures++;
            $display("FAIL stall_frames got=%0d exp=2", rx_len_q.size() - lb);
        end
        nb = cmp_rx(rb);
        checks++;
        if (nb != 0) begin
            failures++; $display("FAIL stall_data got=%0d bad exp=0", nb);
        end
        checks++;
        if (ack_total - a0 != 1500) begin
            failures++;
            $display("FAIL stall_acks got=%0d exp=1500", ack_total - a0);
        end
        checks++;
        if (stall_cnt - s0 == 0) begin
            failures++; $display("FAIL stall_seen got=0 exp=nonzero");
        end
    endtask

    task automatic test_reset_mid();
        int rb, lb, nb;
        do_reset();
        cfg_en_i = 1'b1; cfg_period_i = 8'd0;
        snk_cyc_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            snk_stb_i = 1'b1;
            {snk_we_i, snk_sel_i, snk_adr_i, snk_dat_i} = mk(9, i);
            @(posedge clk);
            #1;
        end
        rst_n_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({src_cyc_o, src_stb_o, snk_ack_o} !== 3'b000) begin
            failures++;
            $display("FAIL mid_rst_out got=%0b%0b%0b exp=000",
                     src_cyc_o, src_stb_o, snk_ack_o);
        end
        checks++;
        if (frames_o !== 32'd0 || dropped_o !== 32'd0) begin
            failures++;
            $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", frames_o, dropped_o);
        end
        @(posedge clk);
        #1;
        snk_cyc_i = 1'b0; snk_stb_i = 1'b0; rst_n_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rb = rx_q.size(); lb = rx_len_q.size();
        exp_q.delete();
        send_frame(10, 20, 10);
        for (int i = 0; i < 20; i++) exp_q.push_back(mk(10, i));
        checks++;
        if (frames_o !== 32'd1 || dropped_o !== 32'd0) begin
            failures++;
            $display("FAIL mid_next_cnt got=%0d/%0d exp=1/0", frames_o, dropped_o);
        end
        nb = cmp_rx(rb);
        checks++;
        if (nb != 0 || rx_len_q.size() - lb != 1) begin
            failures++;
            $display("FAIL mid_next_data got=%0d bad/%0d frames exp=0/1",
                     nb, rx_len_q.size() - lb);
        end
    endtask

    task automatic test_back_to_back();
        int rb, lb, nb;
        do_reset();
        cfg_en_i = 1'b1; cfg_period_i = 8'd2;
        rb = rx_q.size(); lb = rx_len_q.size();
        exp_q.delete();
        for (int f = 1; f <= 6; f++) begin
            send_frame(f, 8, 1);
            if (f % 2 == 1)
                for (int i = 0; i < 8; i++) exp_q.push_back(mk(f, i));
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (frames_o !== 32'd6 || dropped_o !== 32'd3) begin
            failures++;
            $display("FAIL b2b_cnt got=%0d/%0d exp=6/3", frames_o, dropped_o);
        end
        checks++;
        if (rx_len_q.size() - lb != 3 || bad_lens(lb, 8) != 0) begin
            failures++;
            $display("FAIL b2b_frames got=%0d exp=3", rx_len_q.size() - lb);
        end
        nb = cmp_rx(rb);
        checks++;
        if (nb != 0) begin
            failures++; $display("FAIL b2b_data got=%0d bad exp=0", nb);
        end
    endtask

`ifdef FEC_ERASURE_LFSR_EN
    task automatic test_lfsr();
        int          rb, nb, ndrop;
        logic [15:0] l;
        do_reset();
        cfg_en_i = 1'b1; cfg_period_i = 8'd0; cfg_thresh_i = 16'hFFFF;
        rb = rx_q.size(); ndrop = 0; l = 16'hACE1;
        exp_q.delete();
        for (int f = 1; f <= 12; f++) begin
            send_frame(f, 4, 2);
            if (l < 16'hFFFF) ndrop++;
            else for (int i = 0; i < 4; i++) exp_q.push_back(mk(f, i));
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (dropped_o !== 32'(ndrop) || frames_o !== 32'd12) begin
            failures++;
            $display("FAIL lfsr_hi got=%0d exp=%0d", dropped_o, ndrop);
        end
        nb = cmp_rx(rb);
        checks++;
        if (nb != 0) begin
            failures++; $display("FAIL lfsr_hi_data got=%0d bad exp=0", nb);
        end
        do_reset();
        cfg_thresh_i = 16'h0000;
        rb = rx_q.size();
        exp_q.delete();
        for (int f = 1; f <= 6; f++) begin
            send_frame(f, 4, 2);
            for (int i = 0; i < 4; i++) exp_q.push_back(mk(f, i));
        end
        repeat (10) @(posedge clk);
        #1;
        nb = cmp_rx(rb);
        checks++;
        if (dropped_o !== 32'd0 || nb != 0) begin
            failures++;
            $display("FAIL lfsr_lo got=%0d/%0d bad exp=0/0", dropped_o, nb);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_periodic();
        test_passthrough();
        test_stalls();
        test_reset_mid();
        test_back_to_back();
`ifdef FEC_ERASURE_LFSR_EN
        test_lfsr();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
